// File: rtl/dl1_write_buffer.sv
// DL1 -> L2 write-through buffer.
// A FIFO of WB_DEPTH {word address, data} entries. Repeated stores to the same
// word are merged. A two-state drain FSM hands the head entry to L2 using a
// request/acknowledge handshake. DL1 read misses are answered with the
// youngest buffered data for the requested word.
module dl1_write_buffer #(
    parameter int DATA_LENGTH = 32,
    parameter int BYTE_OFFSET = 2,
    parameter int WB_DEPTH    = 4
) (
    input  logic                                 clk_l1,
    input  logic                                 rst,
    input  logic                                 wb_req,
    input  logic [2*DATA_LENGTH-BYTE_OFFSET-1:0] wb_data,
    output logic                                 wb_ack,
    output logic                                 full_flag,
    output logic                                 wb_empty,
    output logic                                 l2_wb_req,
    output logic [DATA_LENGTH-BYTE_OFFSET-1:0]   l2_wb_addr,
    output logic [DATA_LENGTH-1:0]               l2_wb_data,
    input  logic                                 l2_wb_ack,
    input  logic                                 L2_full_flag,
    input  logic [DATA_LENGTH-BYTE_OFFSET-1:0]   lookup_addr,
    output logic                                 lookup_hit,
    output logic [DATA_LENGTH-1:0]               lookup_data
);

    localparam int AW = DATA_LENGTH - BYTE_OFFSET;
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = $clog2(WB_DEPTH + 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                            state_q, state_d;
    logic [WB_DEPTH-1:0]               valid_q, valid_d;
    logic [WB_DEPTH-1:0][AW-1:0]       addr_q, addr_d;
    logic [WB_DEPTH-1:0][DATA_LENGTH-1:0] data_q, data_d;
    logic [PW-1:0]                     head_q, head_d;
    logic [PW-1:0]                     tail_q, tail_d;
    logic [CW-1:0]                     count_q, count_d;
    logic                              wb_ack_q, wb_ack_d;

    logic [AW-1:0]          push_addr;
    logic [DATA_LENGTH-1:0] push_data;
    logic                   push_en, co_hit, coalesce, push_new, pop, full;
    logic [PW-1:0]          co_idx, lk_idx, idx_c, idx_l;

    assign push_addr = wb_data[2*DATA_LENGTH-BYTE_OFFSET-1:DATA_LENGTH];
    assign push_data = wb_data[DATA_LENGTH-1:0];

    // A request is only considered outside the ack cycle, so a held request
    // is never pushed twice.
    assign push_en  = wb_req && !wb_ack_q;
    assign full     = (count_q == CW'(WB_DEPTH));
    assign pop      = (state_q == REQ) && l2_wb_ack;
    assign coalesce = push_en && co_hit;
    assign push_new = push_en && !co_hit && !full;

    // Merge target search: walk head->tail so the youngest match wins; the
    // head entry is excluded while it is being offered to L2.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        idx_c  = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx_c = head_q + PW'(i);
            if (valid_q[idx_c] && addr_q[idx_c] == push_addr &&
                !(state_q == REQ && idx_c == head_q)) begin
                co_hit = 1'b1;
                co_idx = idx_c;
            end
        end
    end

    // Read-miss lookup over every valid entry, locked head included.
    always_comb begin
        lookup_hit = 1'b0;
        lk_idx     = '0;
        idx_l      = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx_l = head_q + PW'(i);
            if (valid_q[idx_l] && addr_q[idx_l] == lookup_addr) begin
                lookup_hit = 1'b1;
                lk_idx     = idx_l;
            end
        end
    end

    assign lookup_data = lookup_hit ? data_q[lk_idx] : '0;

    // Entry storage, pointer and occupancy updates.
    always_comb begin
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        head_d   = head_q;
        tail_d   = tail_q;
        wb_ack_d = coalesce || push_new;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (coalesce) begin
            data_d[co_idx] = push_data;
        end
        if (push_new) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = push_addr;
            data_d[tail_q]  = push_data;
            tail_d          = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push_new) - CW'(pop);
    end

    // Drain FSM: start a request when something is buffered and L2 has room;
    // once raised the request is held until L2 acknowledges it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (count_q != '0 && !L2_full_flag) state_d = REQ;
            REQ:  if (l2_wb_ack)                      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_l1 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wb_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wb_ack_q <= wb_ack_d;
        end
    end

    assign wb_ack     = wb_ack_q;
    assign full_flag  = full;
    assign wb_empty   = (count_q == '0) && (state_q == IDLE);
    assign l2_wb_req  = (state_q == REQ);
    assign l2_wb_addr = (state_q == REQ) ? addr_q[head_q] : '0;
    assign l2_wb_data = (state_q == REQ) ? data_q[head_q] : '0;

endmodule

// File: tb/tb_dl1_write_buffer.sv
// Directed bench for dl1_write_buffer with a drain-order scoreboard.
module tb_dl1_write_buffer;

    logic        clk_l1 = 1'b0;
    logic        rst = 1'b1;
    logic        wb_req = 1'b0;
    logic [61:0] wb_data = '0;
    logic        wb_ack, full_flag, wb_empty, l2_wb_req;
    logic [29:0] l2_wb_addr;
    logic [31:0] l2_wb_data;
    logic        l2_wb_ack = 1'b0;
    logic        L2_full_flag = 1'b0;
    logic [29:0] lookup_addr = '0;
    logic        lookup_hit;
    logic [31:0] lookup_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;
    ent_t sb[$];

    dl1_write_buffer #(.DATA_LENGTH(32), .BYTE_OFFSET(2), .WB_DEPTH(4)) dut (
        .clk_l1(clk_l1), .rst(rst), .wb_req(wb_req), .wb_data(wb_data),
        .wb_ack(wb_ack), .full_flag(full_flag), .wb_empty(wb_empty),
        .l2_wb_req(l2_wb_req), .l2_wb_addr(l2_wb_addr), .l2_wb_data(l2_wb_data),
        .l2_wb_ack(l2_wb_ack), .L2_full_flag(L2_full_flag),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data)
    );

    always #5 clk_l1 = ~clk_l1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds wb_req until wb_ack or budget expiry.
    task automatic push(input logic [29:0] a, input logic [31:0] d, input int budget,
                        output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        wb_req  = 1'b1;
        wb_data = {a, d};
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk_l1);
            if (wb_ack) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        wb_req = 1'b0;
    endtask

    task automatic push_ok(input logic [29:0] a, input logic [31:0] d, input string tag);
        bit got;
        int lat;
        push(a, d, 20, got, lat);
        check(tag, got, 1);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (l2_wb_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_l1);
        end
        if (!ok) check("l2_req_timeout", 0, 1);
    endtask

    task automatic drain_one(input string tag);
        bit   ok;
        ent_t e;
        wait_req(ok);
        if (ok) begin
            if (sb.size() == 0) begin
                check({tag, "_unexpected"}, 1, 0);
            end else begin
                e = sb.pop_front();
                check({tag, "_addr"}, l2_wb_addr, e.a);
                check({tag, "_data"}, l2_wb_data, e.d);
            end
            l2_wb_ack = 1'b1;
            @(negedge clk_l1);
            l2_wb_ack = 1'b0;
            check({tag, "_idle_gap"}, l2_wb_req, 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit   got, got2, ok;
        int   lat;
        ent_t e;

        // Reset state
        @(negedge clk_l1);
        check("rst_wb_ack", wb_ack, 0);
        check("rst_l2_req", l2_wb_req, 0);
        check("rst_l2_addr", l2_wb_addr, 0);
        check("rst_l2_data", l2_wb_data, 0);
        check("rst_full", full_flag, 0);
        check("rst_empty", wb_empty, 1);
        @(negedge clk_l1);
        rst = 1'b0;

        // 1: single push and drain
        push(30'h10, 32'h567, 20, got, lat);
        check("t1_ack", got, 1);
        check("t1_ack_latency", lat, 1);
        e.a = 30'h10; e.d = 32'h567; sb.push_back(e);
        drain_one("t1");
        check("t1_empty", wb_empty, 1);

        // 2: fill while L2 is full, blocked fifth push, in-order drain
        L2_full_flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_ok(30'h10 + 30'(i), 32'hA000 + 32'(i), "t2_fill_ack");
            e.a = 30'h10 + 30'(i); e.d = 32'hA000 + 32'(i); sb.push_back(e);
        end
        check("t2_full", full_flag, 1);
        check("t2_not_empty", wb_empty, 0);
        push(30'h20, 32'h2020, 6, got, lat);
        check("t2_blocked_no_ack", got, 0);
        e.a = 30'h20; e.d = 32'h2020; sb.push_back(e);
        fork
            push(30'h20, 32'h2020, 80, got2, lat);
            begin
                L2_full_flag = 1'b0;
                for (int i = 0; i < 5; i++) drain_one("t2_drain");
            end
        join
        check("t2_pending_accepted", got2, 1);
        check("t2_empty", wb_empty, 1);

        // 3: coalesce while L2 is full
        L2_full_flag = 1'b1;
        push_ok(30'h40, 32'h1, "t3_ack1");
        push_ok(30'h40, 32'h2, "t3_ack2");
        lookup_addr = 30'h40;
        #1;
        check("t3_lookup_hit", lookup_hit, 1);
        check("t3_lookup_data", lookup_data, 32'h2);
        check("t3_not_full", full_flag, 0);
        e.a = 30'h40; e.d = 32'h2; sb.push_back(e);
        L2_full_flag = 1'b0;
        drain_one("t3");
        check("t3_single_entry_empty", wb_empty, 1);

        // 4: push to the locked head becomes a new entry
        push_ok(30'h40, 32'hA, "t4_ackA");
        e.a = 30'h40; e.d = 32'hA; sb.push_back(e);
        wait_req(ok);
        push_ok(30'h40, 32'hB, "t4_ackB");
        e.a = 30'h40; e.d = 32'hB; sb.push_back(e);
        #1;
        check("t4_head_frozen", l2_wb_data, 32'hA);
        check("t4_lookup_youngest", lookup_data, 32'hB);
        drain_one("t4_first");
        check("t4_second_pending", wb_empty, 0);
        drain_one("t4_second");
        check("t4_empty", wb_empty, 1);
        lookup_addr = 30'h40;
        #1;
        check("t4_lookup_miss_data", lookup_data, 0);

        // 5: pushes coinciding with L2 acks, across pointer wrap
        L2_full_flag = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_ok(30'h100 + 30'(i), 32'hC00 + 32'(i), "t5_preload_ack");
            e.a = 30'h100 + 30'(i); e.d = 32'hC00 + 32'(i); sb.push_back(e);
        end
        L2_full_flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_req(ok);
            if (ok) begin
                e = sb.pop_front();
                check("t5_addr", l2_wb_addr, e.a);
                check("t5_data", l2_wb_data, e.d);
                e.a = 30'h102 + 30'(i);
                e.d = $urandom;
                sb.push_back(e);
                l2_wb_ack = 1'b1;
                wb_req    = 1'b1;
                wb_data   = {e.a, e.d};
                @(negedge clk_l1);
                l2_wb_ack = 1'b0;
                check("t5_sim_push_ack", wb_ack, 1);
                wb_req = 1'b0;
                check("t5_never_full", full_flag, 0);
            end
        end
        drain_one("t5_tail0");
        drain_one("t5_tail1");
        check("t5_empty", wb_empty, 1);

        // 6: reset during an active request
        L2_full_flag = 1'b1;
        for (int i = 0; i < 3; i++) push_ok(30'h200 + 30'(i), 32'hD00 + 32'(i), "t6_ack");
        L2_full_flag = 1'b0;
        wait_req(ok);
        lookup_addr = 30'h201;
        #1;
        check("t6_pre_hit", lookup_hit, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_l2_req", l2_wb_req, 0);
        check("t6_rst_empty", wb_empty, 1);
        check("t6_rst_wb_ack", wb_ack, 0);
        @(negedge clk_l1);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            lookup_addr = 30'h200 + 30'(i);
            #1;
            check("t6_lookup_cleared", lookup_hit, 0);
        end
        @(negedge clk_l1);
        check("t6_stays_idle", l2_wb_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dl1_write_buffer.md
Name: dl1_write_buffer

Overview:
- Write-through buffer between the DL1 data cache and L2.
- Accepts {word address, data} store entries from DL1 and holds them in a FIFO of WB_DEPTH entries.
- Drains entries to L2 one at a time using a request/acknowledge handshake.
- Merges repeated stores to the same word, and answers DL1 read-miss lookups with the youngest buffered data so a miss never returns stale L2 data.

Parameters:
DATA_LENGTH, 32, data/address width
BYTE_OFFSET, 2, byte-offset bits dropped from addresses
WB_DEPTH, 4, number of buffer entries (power of 2, >=2)

Ports:
clk_l1  in  1  L1 clock domain clock
rst  in  1  asynchronous reset, active-high
wb_req  in  1  DL1 push request
wb_data  in  2*DATA_LENGTH-BYTE_OFFSET  {addr[31:2], data[31:0]}
wb_ack  out  1  registered one-cycle push-accept pulse
full_flag  out  1  count==WB_DEPTH
wb_empty  out  1  count==0 and drain FSM in IDLE
l2_wb_req  out  1  drain request to L2
l2_wb_addr  out  DATA_LENGTH-BYTE_OFFSET  head word address
l2_wb_data  out  DATA_LENGTH  head data
l2_wb_ack  in  1  L2 accepted head entry
L2_full_flag  in  1  L2 cannot accept writes
lookup_addr  in  DATA_LENGTH-BYTE_OFFSET  DL1 miss word address
lookup_hit  out  1  combinational: a valid entry matches lookup_addr
lookup_data  out  DATA_LENGTH  data of youngest matching entry, 0 if no hit

Behaviour:
- Reset (asynchronous, any state): all entries invalid; count=0; head and tail pointers 0; FSM=IDLE.
- Output values during reset: wb_ack=0, l2_wb_req=0, l2_wb_addr/l2_wb_data=0, full_flag=0, wb_empty=1.
- Push window: a push is considered when wb_req=1 and wb_ack=0. In the cycle wb_ack is high, wb_req is ignored, so a held request is never double-pushed. Maximum rate is one push per 2 cycles.
- Coalesce: if the push address matches a valid entry that is not locked, that entry's data is overwritten; count is unchanged and wb_ack pulses next cycle. This is allowed even when full.
- Normal push: with no coalesce match and count<WB_DEPTH, write at tail, tail++ (wraps modulo WB_DEPTH), count++, wb_ack pulses next cycle.
- Full without a match: no accept and no wb_ack; DL1 holds wb_req.
- Full is evaluated on registered count. A pop in the same cycle does not free space for that cycle's push.
- Drain FSM states are IDLE and REQ.
- IDLE -> REQ when count>0 and L2_full_flag=0. At that edge the head entry is locked: no coalesce into it and its outputs are frozen.
- In REQ: l2_wb_req=1; l2_wb_addr/l2_wb_data show the head entry, stable until ack.
- On l2_wb_ack in REQ: invalidate head, head++ (wraps), count--, go to IDLE. There is always one idle cycle between drains.
- l2_wb_ack in IDLE is ignored.
- L2_full_flag rising while in REQ does not withdraw the request.
- Simultaneous push and pop: both apply; count is net unchanged.
- A push whose address equals the locked head enters as a new entry.
- Lookup: compares all valid entries, including the locked head. On multiple matches the youngest (closest to tail) wins. A push in the current cycle is not visible until the next cycle.
- Counter width is $clog2(WB_DEPTH+1); pointers are $clog2(WB_DEPTH) bits.

Test Plan:
1. Reset, then push {addr=30'h10, data=32'h567} with L2_full_flag=0 -> wb_ack one cycle later; l2_wb_req high with l2_wb_addr=30'h10, l2_wb_data=32'h567; after l2_wb_ack, wb_empty=1.
2. Hold L2_full_flag=1 and push 4 distinct addresses 30'h10..30'h13 -> full_flag=1.
   - A 5th push to 30'h20 gets no wb_ack.
   - Release L2_full_flag: entries drain in order 10,11,12,13 and the pending push is then accepted.
3. Coalesce: with L2_full_flag=1, push 30'h40/32'h1 then 30'h40/32'h2 -> count=1; lookup_addr=30'h40 gives lookup_hit=1, lookup_data=32'h2; drain writes 32'h2.
4. Locked head: push 30'h40/32'hA, wait until l2_wb_req=1, push 30'h40/32'hB -> count=2; l2_wb_data stays 32'hA; lookup_data=32'hB; two drains occur, A then B.
5. Wrap and simultaneous events: run 10 push/drain pairs with pushes coinciding with l2_wb_ack -> FIFO order preserved across pointer wrap; count never exceeds 4.
6. Assert rst while l2_wb_req=1 with 3 entries held -> l2_wb_req=0 immediately; wb_empty=1; lookup_hit=0 for all previously held addresses after release.
